matching_pipe_elastic: RTL and testbench

// - Parametrised elastic pipeline carrying matching-stage results (word, match types, locations, match size) between compressor stages.
// - Adds what a plain stage register lacks: valid/ready handshake, configurable depth, registered input ready via skid slot, flush, occupancy.
// - Sits between the dictionary-match comparator and the length/encode stage; stalls cleanly when the encoder backpressures.

---
 rtl/matching_pkg.sv | 31 +++
 rtl/matching_pipe_slot.sv | 41 ++++
 rtl/matching_pipe_elastic.sv | 171 +++++++++++++++++
 tb/tb_matching_pipe_elastic.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matching_pkg.sv
// Shared types for the matching-stage elastic pipeline.
// Provides the field widths, the packed beat payload and its idle (no-match) value.
package matching_pkg;

   localparam int unsigned MI_WORD_W = 64;
   localparam int unsigned MI_TM2_W  = 4;
   localparam int unsigned MI_TM1_W  = 2;
   localparam int unsigned MI_LOC_W  = 4;
   localparam int unsigned MI_MS_W   = 2;

   // One matching-stage result as carried between compressor stages.
   typedef struct packed {
      logic [MI_WORD_W-1:0] word;
      logic [MI_TM2_W-1:0]  tm2;
      logic [MI_TM1_W-1:0]  tm1;
      logic [MI_LOC_W-1:0]  loc2;
      logic [MI_LOC_W-1:0]  loc4;
      logic [MI_MS_W-1:0]   ms;
   } match_info_t;

   // Idle payload: all-ones match types encode "no match".
   localparam match_info_t MATCH_INFO_RST = '{
      word: '0,
      tm2:  '1,
      tm1:  '1,
      loc2: '0,
      loc4: '0,
      ms:   '0
   };

endpackage : matching_pkg

// File: rtl/matching_pipe_slot.sv
// One valid + payload register of the elastic pipeline.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_clear          synchronous clear to idle (valid 0, idle payload)
//   i_load           capture i_valid / i_info this cycle
//   i_valid, i_info  next beat (an invalid beat must carry the idle payload)
//   o_valid, o_info  registered slot contents
module matching_pipe_slot
   import matching_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_load,
   input  logic        i_valid,
   input  match_info_t i_info,
   output logic        o_valid,
   output match_info_t o_info
);

   logic        valid_q;
   match_info_t info_q;

   // Slot register; clear has priority over load.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q <= 1'b0;
         info_q  <= MATCH_INFO_RST;
      end else if (i_clear) begin
         valid_q <= 1'b0;
         info_q  <= MATCH_INFO_RST;
      end else if (i_load) begin
         valid_q <= i_valid;
         info_q  <= i_info;
      end
   end

   assign o_valid = valid_q;
   assign o_info  = info_q;

endmodule : matching_pipe_slot

// File: rtl/matching_pipe_elastic.sv
// Elastic valid/ready pipeline for matching-stage results, DEPTH stages plus
// one skid slot so the upstream ready is a register, with flush and occupancy.
// Ports:
//   i_clk, i_reset             clock, asynchronous active-high reset
//   i_flush                    synchronous drop of every held beat
//   i_valid, o_ready           upstream handshake (o_ready registered)
//   i_word .. i_match_s        upstream payload
//   o_valid, i_ready           downstream handshake
//   o_word .. o_match_s        head-of-pipe payload (idle values when invalid)
//   o_count                    beats held in skid + stages
// The payload widths must equal the matching_pkg field widths.
module matching_pipe_elastic
   import matching_pkg::*;
#(
   parameter int unsigned WIDTH = MI_WORD_W,
   parameter int unsigned TM2_W = MI_TM2_W,
   parameter int unsigned TM1_W = MI_TM1_W,
   parameter int unsigned LOC_W = MI_LOC_W,
   parameter int unsigned MS_W  = MI_MS_W,
   parameter int unsigned DEPTH = 2
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_flush,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [WIDTH-1:0]              i_word,
   input  logic [TM2_W-1:0]              i_type_matched2,
   input  logic [TM1_W-1:0]              i_type_matched1,
   input  logic [LOC_W-1:0]              i_location2,
   input  logic [LOC_W-1:0]              i_location4,
   input  logic [MS_W-1:0]               i_match_s,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [WIDTH-1:0]              o_word,
   output logic [TM2_W-1:0]              o_type_matched2,
   output logic [TM1_W-1:0]              o_type_matched1,
   output logic [LOC_W-1:0]              o_location2,
   output logic [LOC_W-1:0]              o_location4,
   output logic [MS_W-1:0]               o_match_s,
   output logic [$clog2(DEPTH+2)-1:0]    o_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 2);

   match_info_t      in_info;
   logic             in_xfer;
   logic             out_xfer;

   logic             skid_valid;
   match_info_t      skid_info;
   logic             skid_valid_d;
   match_info_t      skid_info_d;

   logic [DEPTH-1:0] stg_valid;
   logic [DEPTH-1:0] stg_acc;
   match_info_t      stg_info [DEPTH];
   logic [DEPTH-1:0] src_valid;
   match_info_t      src_info [DEPTH];

   logic             ready_q, ready_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign in_info = '{
      word: i_word,
      tm2:  i_type_matched2,
      tm1:  i_type_matched1,
      loc2: i_location2,
      loc4: i_location4,
      ms:   i_match_s
   };

   assign in_xfer  = i_valid & ready_q;
   assign out_xfer = stg_valid[DEPTH-1] & i_ready;

   // Stage k can load when it, or any stage after it, has a hole, or the
   // whole tail is full and the downstream takes the head this cycle.
   always_comb begin
      logic acc;
      stg_acc = '0;
      acc     = i_ready;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         acc        = acc | ~stg_valid[k];
         stg_acc[k] = acc;
      end
   end

   // Stage sources: stage 0 prefers the skid beat (older) over the input;
   // an empty source carries the idle payload so holes stay at reset values.
   always_comb begin
      src_valid = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         src_info[k] = MATCH_INFO_RST;
      end
      src_valid[0] = skid_valid | in_xfer;
      src_info[0]  = skid_valid ? skid_info :
                     (in_xfer ? in_info : MATCH_INFO_RST);
      for (int k = 1; k < int'(DEPTH); k++) begin
         src_valid[k] = stg_valid[k-1];
         src_info[k]  = stg_info[k-1];
      end
   end

   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
      matching_pipe_slot u_slot (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_clear (i_flush),
         .i_load  (stg_acc[g]),
         .i_valid (src_valid[g]),
         .i_info  (src_info[g]),
         .o_valid (stg_valid[g]),
         .o_info  (stg_info[g])
      );
   end

   // Skid holds an accepted beat only while stage 0 is blocked.
   always_comb begin
      skid_valid_d = ~stg_acc[0] & (skid_valid | in_xfer);
      skid_info_d  = MATCH_INFO_RST;
      if (skid_valid_d) begin
         skid_info_d = skid_valid ? skid_info : in_info;
      end
   end

   matching_pipe_slot u_skid (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (i_flush),
      .i_load  (1'b1),
      .i_valid (skid_valid_d),
      .i_info  (skid_info_d),
      .o_valid (skid_valid),
      .o_info  (skid_info)
   );

   // Next ready and occupancy.
   always_comb begin
      ready_d = ~skid_valid_d;
      count_d = count_q;
      if (in_xfer && !out_xfer) begin
         count_d = count_q + CNT_W'(1);
      end else if (!in_xfer && out_xfer) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ready_q <= 1'b1;
         count_q <= '0;
      end else if (i_flush) begin
         ready_q <= 1'b1;
         count_q <= '0;
      end else begin
         ready_q <= ready_d;
         count_q <= count_d;
      end
   end

   assign o_ready         = ready_q;
   assign o_count         = count_q;
   assign o_valid         = stg_valid[DEPTH-1];
   assign o_word          = stg_info[DEPTH-1].word;
   assign o_type_matched2 = stg_info[DEPTH-1].tm2;
   assign o_type_matched1 = stg_info[DEPTH-1].tm1;
   assign o_location2     = stg_info[DEPTH-1].loc2;
   assign o_location4     = stg_info[DEPTH-1].loc4;
   assign o_match_s       = stg_info[DEPTH-1].ms;

endmodule : matching_pipe_elastic

// File: tb/tb_matching_pipe_elastic.sv
// Scoreboard bench for matching_pipe_elastic: the driver pushes every
// accepted beat, an independent monitor checks the head payload and occupancy.
module tb_matching_pipe_elastic;
   import matching_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = $clog2(DEPTH + 2);

   logic             clk;
   logic             i_reset, i_flush, i_valid, i_ready;
   logic             o_ready, o_valid;
   match_info_t      cur;
   match_info_t      out_info;
   logic [63:0]      o_word;
   logic [3:0]       o_tm2;
   logic [1:0]       o_tm1;
   logic [3:0]       o_loc2, o_loc4;
   logic [1:0]       o_ms;
   logic [CNT_W-1:0] o_count;

   int checks = 0;
   int errors = 0;
   match_info_t sb[$];
   int mcnt = 0;

   matching_pipe_elastic #(.DEPTH(DEPTH)) dut (
      .i_clk           (clk),
      .i_reset         (i_reset),
      .i_flush         (i_flush),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_word          (cur.word),
      .i_type_matched2 (cur.tm2),
      .i_type_matched1 (cur.tm1),
      .i_location2     (cur.loc2),
      .i_location4     (cur.loc4),
      .i_match_s       (cur.ms),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_word          (o_word),
      .o_type_matched2 (o_tm2),
      .o_type_matched1 (o_tm1),
      .o_location2     (o_loc2),
      .o_location4     (o_loc4),
      .o_match_s       (o_ms),
      .o_count         (o_count)
   );

   assign out_info = {o_word, o_tm2, o_tm1, o_loc2, o_loc4, o_ms};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog expired");
   end

   // Payload fields derived from the word so each beat is distinct.
   function automatic match_info_t mk(input logic [63:0] w);
      match_info_t m;
      m      = MATCH_INFO_RST;
      m.word = w;
      m.tm2  = w[3:0] ^ 4'h5;
      m.tm1  = w[5:4];
      m.loc2 = w[11:8];
      m.loc4 = w[15:12];
      m.ms   = w[17:16];
      return m;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: head payload vs scoreboard (also while stalled), occupancy model.
   always @(negedge clk) begin
      logic in_x, out_x;
      if (i_reset) begin
         sb.delete();
         mcnt = 0;
      end else begin
         chk("count", 128'(o_count), 128'(mcnt));
         if (o_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat actual=%0h required=none", o_word);
            end else begin
               chk("payload", 128'(out_info), 128'(sb[0]));
               if (i_ready) void'(sb.pop_front());
            end
         end
         in_x  = i_valid & o_ready;
         out_x = o_valid & i_ready;
         if (i_flush) begin
            sb.delete();
            mcnt = 0;
         end else begin
            mcnt = mcnt + int'(in_x) - int'(out_x);
         end
      end
   end

   // Sample point for the driver: record accepted beats.
   task automatic sample();
      @(negedge clk);
      if (i_valid && o_ready && !i_flush && !i_reset) sb.push_back(cur);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 128'(o_valid), 128'(0));
      chk({tag, "_ready"}, 128'(o_ready), 128'(1));
      chk({tag, "_count"}, 128'(o_count), 128'(0));
      chk({tag, "_tm1"},   128'(o_tm1),   128'(2'b11));
      chk({tag, "_tm2"},   128'(o_tm2),   128'(4'hF));
      chk({tag, "_word"},  128'(o_word),  128'(0));
   endtask

   initial begin
      i_reset = 1'b1;
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      cur     = mk(64'h0);
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      i_reset = 1'b0;
      i_ready = 1'b1;
      adv();

      // Streaming: 8 back-to-back beats, head valid DEPTH cycles after first accept.
      for (int k = 0; k <= 8 + int'(DEPTH); k++) begin
         i_valid = (k < 8);
         cur     = mk(64'(k + 1));
         sample();
         chk("stream_valid", 128'(o_valid), 128'((k >= int'(DEPTH)) && (k < 8 + int'(DEPTH))));
         if (k >= int'(DEPTH) && k < 8 + int'(DEPTH))
            chk("stream_word", 128'(o_word), 128'(k - int'(DEPTH) + 1));
         if (k >= int'(DEPTH) && k <= 8)
            chk("stream_full_count", 128'(o_count), 128'(DEPTH));
         adv();
      end
      i_valid = 1'b0;

      // Backpressure: DEPTH+2 offered, DEPTH+1 held, last one refused.
      i_ready = 1'b0;
      for (int k = 0; k < int'(DEPTH) + 2; k++) begin
         i_valid = 1'b1;
         cur     = mk(64'(k + 1));
         sample();
         if (k == int'(DEPTH) + 1) chk("bp_refused", 128'(o_ready), 128'(0));
         adv();
      end
      i_valid = 1'b0;
      sample();
      chk("bp_count", 128'(o_count), 128'(DEPTH + 1));
      chk("bp_ready", 128'(o_ready), 128'(0));
      chk("bp_head",  128'(o_word),  128'(1));
      adv();
      sample();
      chk("bp_stable", 128'(o_word), 128'(1));
      adv();
      i_ready = 1'b1;
      sample();
      adv();
      sample();
      chk("bp_ready_back", 128'(o_ready), 128'(1));
      chk("bp_next", 128'(o_word), 128'(2));
      adv();
      repeat (DEPTH + 3) begin sample(); adv(); end

      // Flush with two beats held and a beat offered in the same cycle.
      i_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         i_valid = 1'b1;
         cur     = mk(64'h21 + 64'(k));
         sample();
         adv();
      end
      cur     = mk(64'hAA);
      i_flush = 1'b1;
      sample();
      adv();
      i_flush = 1'b0;
      i_valid = 1'b0;
      sample();
      chk_idle("flush");
      adv();
      i_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i_valid = 1'b1;
         cur     = mk(64'h31 + 64'(k));
         sample();
         adv();
      end
      i_valid = 1'b0;
      repeat (DEPTH + 3) begin sample(); adv(); end

      // Random valid/ready traffic with occasional flush.
      for (int n = 0; n < 10000; n++) begin
         i_valid = ($urandom_range(0, 3) != 0);
         i_ready = ($urandom_range(0, 3) != 0);
         i_flush = ($urandom_range(0, 299) == 0);
         cur     = mk({$urandom, $urandom});
         sample();
         chk("capacity", 128'(o_count <= CNT_W'(DEPTH + 1)), 128'(1));
         adv();
      end
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      repeat (DEPTH + 3) begin sample(); adv(); end

      // Reset asserted mid-cycle during streaming.
      for (int k = 0; k < 4; k++) begin
         i_valid = 1'b1;
         cur     = mk(64'h51 + 64'(k));
         sample();
         adv();
      end
      #2;
      i_reset = 1'b1;
      #1;
      chk_idle("midreset");
      i_valid = 1'b0;
      adv();
      i_reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         i_valid = 1'b1;
         cur     = mk(64'h61 + 64'(k));
         sample();
         adv();
      end
      i_valid = 1'b0;

      // Bounded drain.
      for (int w = 0; w < 50 && sb.size() != 0; w++) begin
         sample();
         adv();
      end
      chk("drain", 128'(sb.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_matching_pipe_elastic
